// File: rtl/rpn_calculator.sv
// rpn_calculator: infix token stream -> shunting-yard reduction on an operand
// stack, with the result of each '=' presented on a strobe/ack port.
module rpn_calculator #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        input_stb,
  input  logic [31:0] input_data,
  input  logic        is_input_operator,
  output logic        input_ack,
  output logic        output_stb,
  output logic [31:0] output_data,
  input  logic        output_ack
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_ACK, S_RESULT} state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_num [DEPTH];
  logic [CW-1:0]   r_num_cnt;
  logic [2:0]      r_op [DEPTH];
  logic [CW-1:0]   r_op_cnt;
  logic [2:0]      r_pend;
  logic            r_input_ack;
  logic            r_output_stb;
  logic [DW-1:0]   r_output_data;

  logic [2:0]      w_tok_code;
  logic [DW-1:0]   w_num_top, w_num_sec, w_red_res;
  logic [2:0]      w_op_top, w_op_sec;
  logic [AW-1:0]   w_num_wr_idx;
  logic [CW-1:0]   w_num_cnt_red;
  logic            w_push_num, w_reduce, w_push_op, w_load_pend;
  logic            w_ack_nxt, w_res_load, w_clear;
  logic [2:0]      w_op_code;
  logic [DW-1:0]   w_res_val;

  // '=' binds weakest so it drains every pending operator
  function automatic logic [1:0] f_prec(input logic [2:0] code);
    case (code)
      OP_MUL:         f_prec = 2'd2;
      OP_ADD, OP_SUB: f_prec = 2'd1;
      default:        f_prec = 2'd0;
    endcase
  endfunction

  assign w_tok_code  = input_data[2:0];
  assign input_ack   = r_input_ack;
  assign output_stb  = r_output_stb;
  assign output_data = r_output_data;

  // Stack tops and the single reduction this cycle would perform (missing operands read as 0)
  always_comb begin
    w_num_top     = (r_num_cnt != '0) ? r_num[AW'(r_num_cnt - CW'(1))] : '0;
    w_num_sec     = (r_num_cnt > CW'(1)) ? r_num[AW'(r_num_cnt - CW'(2))] : '0;
    w_op_top      = (r_op_cnt != '0) ? r_op[AW'(r_op_cnt - CW'(1))] : 3'b000;
    w_op_sec      = (r_op_cnt > CW'(1)) ? r_op[AW'(r_op_cnt - CW'(2))] : 3'b000;
    w_num_wr_idx  = (r_num_cnt > CW'(1)) ? AW'(r_num_cnt - CW'(2)) : '0;
    w_num_cnt_red = (r_num_cnt > CW'(1)) ? CW'(r_num_cnt - CW'(1)) : CW'(1);
    case (w_op_top)
      OP_MUL:  w_red_res = w_num_sec * w_num_top;
      OP_ADD:  w_red_res = w_num_sec + w_num_top;
      OP_SUB:  w_red_res = w_num_sec - w_num_top;
      default: w_red_res = w_num_sec;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_push_num  = 1'b0;
    w_reduce    = 1'b0;
    w_push_op   = 1'b0;
    w_op_code   = w_tok_code;
    w_load_pend = 1'b0;
    w_ack_nxt   = 1'b0;
    w_res_load  = 1'b0;
    w_res_val   = w_num_top;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (input_stb) begin
          if (!is_input_operator) begin
            w_push_num  = 1'b1;
            w_ack_nxt   = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            case (w_tok_code)
              OP_MUL, OP_ADD, OP_SUB, OP_EQ: begin
                if (r_op_cnt != '0 && f_prec(w_op_top) >= f_prec(w_tok_code)) begin
                  w_load_pend = 1'b1;
                  w_state_nxt = S_REDUCE;
                end else if (w_tok_code == OP_EQ) begin
                  w_res_load  = 1'b1;
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = S_RESULT;
                end else begin
                  w_push_op   = 1'b1;
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = S_ACK;
                end
              end
              default: begin
                w_ack_nxt   = 1'b1;
                w_state_nxt = S_ACK;
              end
            endcase
          end
        end
      end
      S_REDUCE: begin
        w_reduce = 1'b1;
        if (r_op_cnt > CW'(1) && f_prec(w_op_sec) >= f_prec(r_pend)) begin
          w_state_nxt = S_REDUCE;
        end else if (r_pend == OP_EQ) begin
          w_res_load  = 1'b1;
          w_res_val   = w_red_res;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_RESULT;
        end else begin
          w_push_op   = 1'b1;
          w_op_code   = r_pend;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: w_state_nxt = S_IDLE;
      S_RESULT: begin
        if (output_ack) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/operator stacks; a reduction that ends by pushing the pending operator overwrites the popped slot
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_num[i] <= '0;
        r_op[i]  <= '0;
      end
      r_num_cnt <= '0;
      r_op_cnt  <= '0;
      r_pend    <= '0;
    end else if (w_clear) begin
      r_num_cnt <= '0;
      r_op_cnt  <= '0;
    end else begin
      if (w_push_num && r_num_cnt < CW'(DEPTH)) begin
        r_num[AW'(r_num_cnt)] <= input_data;
        r_num_cnt             <= r_num_cnt + CW'(1);
      end
      if (w_reduce) begin
        r_num[w_num_wr_idx] <= w_red_res;
        r_num_cnt           <= w_num_cnt_red;
        if (w_push_op) r_op[AW'(r_op_cnt - CW'(1))] <= w_op_code;
        else           r_op_cnt <= r_op_cnt - CW'(1);
      end else if (w_push_op && r_op_cnt < CW'(DEPTH)) begin
        r_op[AW'(r_op_cnt)] <= w_op_code;
        r_op_cnt            <= r_op_cnt + CW'(1);
      end
      if (w_load_pend) r_pend <= w_tok_code;
    end
  end

  // Registered handshake outputs; result data is held after the handshake
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_input_ack   <= 1'b0;
      r_output_stb  <= 1'b0;
      r_output_data <= '0;
    end else begin
      r_input_ack <= w_ack_nxt;
      if (w_res_load) begin
        r_output_stb  <= 1'b1;
        r_output_data <= w_res_val;
      end else if (w_clear) begin
        r_output_stb  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rpn_calculator.sv
// Directed bench for rpn_calculator: results, ack latencies, result hold, reset.
module tb_rpn_calculator;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        input_stb = 1'b0;
  logic [31:0] input_data = '0;
  logic        is_input_operator = 1'b0;
  logic        input_ack;
  logic        output_stb;
  logic [31:0] output_data;
  logic        output_ack = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] MUL = 32'd1;
  localparam logic [31:0] ADD = 32'd2;
  localparam logic [31:0] SUB = 32'd3;
  localparam logic [31:0] EQ  = 32'd4;
  localparam logic [31:0] BAD = 32'd7;

  rpn_calculator #(.DEPTH(8)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .input_stb         (input_stb),
    .input_data        (input_data),
    .is_input_operator (is_input_operator),
    .input_ack         (input_ack),
    .output_stb        (output_stb),
    .output_data       (output_data),
    .output_ack        (output_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
    else
      n_pass++;
  endtask

  // Offer one token and return cycles from sampling edge to visible ack
  task automatic send(input bit op, input logic [31:0] d, output int lat);
    bit got = 1'b0;
    input_stb = 1'b1;
    is_input_operator = op;
    input_data = d;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (input_ack) got = 1'b1;
    end
    input_stb = 1'b0;
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    if (!(op && d[2:0] == 3'b100)) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic num(input string tag, input logic [31:0] v);
    int lat;
    send(1'b0, v, lat);
    chk({tag, "_num_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic opr(input string tag, input logic [31:0] c, input int exp_lat);
    int lat;
    send(1'b1, c, lat);
    chk({tag, "_op_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  // '=' then result checks, optional held-off ack with a token offered meanwhile
  task automatic finish(input string tag, input logic [31:0] exp, input int exp_lat,
                        input int delay, input bit offer);
    int lat;
    send(1'b1, EQ, lat);
    chk({tag, "_eq_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_stb"}, 32'(output_stb), 32'd1);
    chk({tag, "_res"}, output_data, exp);
    if (offer) begin
      input_stb = 1'b1;
      is_input_operator = 1'b0;
      input_data = 32'd99;
    end
    for (int i = 0; i < delay; i++) begin
      @(posedge CLK); #1;
      chk({tag, "_hold_stb"}, 32'(output_stb), 32'd1);
      chk({tag, "_hold_res"}, output_data, exp);
      chk({tag, "_hold_noack"}, 32'(input_ack), 32'd0);
    end
    input_stb = 1'b0;
    output_ack = 1'b1;
    @(posedge CLK); #1;
    output_ack = 1'b0;
    chk({tag, "_stb_clr"}, 32'(output_stb), 32'd0);
    chk({tag, "_res_kept"}, output_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 want 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iack", 32'(input_ack), 32'd0);
    chk("rst_ostb", 32'(output_stb), 32'd0);
    chk("rst_odata", output_data, 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // 3 + 4 = 7
    num("e1", 32'd3); opr("e1", ADD, 1); num("e1", 32'd4);
    finish("e1", 32'd7, 2, 1, 1'b0);

    // 2 + 3 * 4 = 14
    num("e2", 32'd2); opr("e2", ADD, 1); num("e2", 32'd3); opr("e2", MUL, 1); num("e2", 32'd4);
    finish("e2", 32'd14, 3, 0, 1'b0);

    // lone '=' on empty stacks gives 0
    finish("e0", 32'd0, 1, 0, 1'b0);

    // 2 * 3 + 4 = 10
    num("e3", 32'd2); opr("e3", MUL, 1); num("e3", 32'd3); opr("e3", ADD, 2); num("e3", 32'd4);
    finish("e3", 32'd10, 2, 0, 1'b0);

    // 10 - 4 - 3 = 3
    num("e4", 32'd10); opr("e4", SUB, 1); num("e4", 32'd4); opr("e4", SUB, 2); num("e4", 32'd3);
    finish("e4", 32'd3, 2, 0, 1'b0);

    // -5 * 6 = -30
    num("e5", 32'hFFFF_FFFB); opr("e5", MUL, 1); num("e5", 32'd6);
    finish("e5", 32'hFFFF_FFE2, 2, 0, 1'b0);

    // 2147483647 + 1 wraps
    num("e6", 32'h7FFF_FFFF); opr("e6", ADD, 1); num("e6", 32'd1);
    finish("e6", 32'h8000_0000, 2, 0, 1'b0);

    // 1 + 1 = 2 with a 5-cycle held ack and a token offered meanwhile, then 7 - 9 = -2
    num("e7", 32'd1); opr("e7", ADD, 1); num("e7", 32'd1);
    finish("e7", 32'd2, 2, 5, 1'b1);
    num("e8", 32'd7); opr("e8", SUB, 1); num("e8", 32'd9);
    finish("e8", 32'hFFFF_FFFE, 2, 0, 1'b0);

    // 5 + 6, reset, 8 = 8
    num("e9", 32'd5); opr("e9", ADD, 1); num("e9", 32'd6);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("mid_rst_iack", 32'(input_ack), 32'd0);
    chk("mid_rst_ostb", 32'(output_stb), 32'd0);
    chk("mid_rst_odata", output_data, 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    num("e10", 32'd8);
    finish("e10", 32'd8, 1, 0, 1'b0);

    // 4, invalid code 7, + 1 = 5
    num("e11", 32'd4); opr("e11", BAD, 1); opr("e11", ADD, 1); num("e11", 32'd1);
    finish("e11", 32'd5, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
